// File: rtl/instruction_prefetch_if.sv
// Instruction prefetch bundle: redirect control, instruction-memory port and
// decode-side queue head. The prefetch unit uses the master view; the
// surrounding pipeline/memory uses the slave view.
interface instruction_prefetch_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 4
);
    localparam int LEVEL_W = $clog2(DEPTH + 1);

    // redirect (branch / exception)
    logic                   redirect_i;
    logic [ADDR_WIDTH-1:0]  redirect_pc_i;

    // instruction memory port
    logic                   mem_req_o;
    logic [ADDR_WIDTH-1:0]  mem_addr_o;
    logic                   mem_ack_i;
    logic [INSTR_WIDTH-1:0] mem_instr_i;

    // decode side
    logic                   instr_valid_o;
    logic [INSTR_WIDTH-1:0] instr_o;
    logic [ADDR_WIDTH-1:0]  pc_o;
    logic                   instr_ready_i;
    logic [LEVEL_W-1:0]     level_o;

    modport master (
        input  redirect_i, redirect_pc_i,
        output mem_req_o, mem_addr_o,
        input  mem_ack_i, mem_instr_i,
        output instr_valid_o, instr_o, pc_o,
        input  instr_ready_i,
        output level_o
    );

    modport slave (
        output redirect_i, redirect_pc_i,
        input  mem_req_o, mem_addr_o,
        output mem_ack_i, mem_instr_i,
        input  instr_valid_o, instr_o, pc_o,
        output instr_ready_i,
        input  level_o
    );
endinterface

// File: rtl/instruction_prefetch.sv
// Instruction prefetch queue: fetches sequential instructions from memory into
// a DEPTH-entry FIFO of {pc, instr} pairs and hands them to decode. A redirect
// flushes the FIFO and restarts fetch at the redirect target.
module instruction_prefetch #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter int                    DEPTH       = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    PC_STEP     = 4
) (
    input  logic                  clk,
    input  logic                  rst_i,
    instruction_prefetch_if.master bus
);
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LEVEL_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]       head_reg, head_next;
    logic [PTR_W-1:0]       tail_reg, tail_next;
    logic [LEVEL_W-1:0]     level_reg, level_next;
    logic [ADDR_WIDTH-1:0]  fetch_pc_reg, fetch_pc_next;

    // Entry storage; contents are don't-care while not counted by level_reg.
    logic [ADDR_WIDTH-1:0]  pc_store  [DEPTH];
    logic [INSTR_WIDTH-1:0] instr_store [DEPTH];

    logic full, empty, push, pop;

    assign full  = (level_reg == LEVEL_W'(DEPTH));
    assign empty = (level_reg == '0);

    // Request depends only on registered occupancy and reset, so a pop in the
    // same cycle never re-opens a full queue (no full-bypass path).
    assign bus.mem_req_o  = !rst_i && !full;
    assign bus.mem_addr_o = fetch_pc_reg;

    // A redirect cancels both sides: the acked word and the pop are dropped.
    assign push = bus.mem_req_o && bus.mem_ack_i && !bus.redirect_i;
    assign pop  = !empty && bus.instr_ready_i && !bus.redirect_i;

    // Head is read straight out of storage; forced to zero while empty so the
    // outputs are deterministic after reset or flush.
    assign bus.instr_valid_o = !empty;
    assign bus.instr_o       = empty ? '0 : instr_store[head_reg];
    assign bus.pc_o          = empty ? '0 : pc_store[head_reg];
    assign bus.level_o       = level_reg;

    // Next-state for pointers, occupancy and fetch PC.
    always_comb begin
        head_next     = head_reg;
        tail_next     = tail_reg;
        level_next    = level_reg;
        fetch_pc_next = fetch_pc_reg;
        if (bus.redirect_i) begin
            head_next     = '0;
            tail_next     = '0;
            level_next    = '0;
            fetch_pc_next = bus.redirect_pc_i;
        end else begin
            if (push) begin
                tail_next     = tail_reg + PTR_W'(1);
                fetch_pc_next = fetch_pc_reg + ADDR_WIDTH'(PC_STEP);
            end
            if (pop) begin
                head_next = head_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_next = level_reg + LEVEL_W'(1);
                2'b01:   level_next = level_reg - LEVEL_W'(1);
                default: level_next = level_reg;
            endcase
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            level_reg    <= '0;
            fetch_pc_reg <= RESET_PC;
        end else begin
            head_reg     <= head_next;
            tail_reg     <= tail_next;
            level_reg    <= level_next;
            fetch_pc_reg <= fetch_pc_next;
        end
    end

    // Tail write of the fetched pair; push is already gated by reset.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_store[tail_reg]    <= fetch_pc_reg;
            instr_store[tail_reg] <= bus.mem_instr_i;
        end
    end
endmodule

// File: tb/tb_instruction_prefetch.sv
// Randomised and directed bench for instruction_prefetch, checked every cycle
// against a queue-based reference model.
module tb_instruction_prefetch;
    localparam int          AW      = 32;
    localparam int          IW      = 32;
    localparam int          DEPTH   = 4;
    localparam logic [31:0] RST_PC  = 32'h100;
    localparam int          STEP    = 4;

    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    instruction_prefetch_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DEPTH)) bus ();

    instruction_prefetch #(
        .ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DEPTH),
        .RESET_PC(RST_PC), .PC_STEP(STEP)
    ) dut (
        .clk   (clk),
        .rst_i (rst_i),
        .bus   (bus.master)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t      q[$];
    logic [31:0] fpc;
    bit          model_init = 0;
    int          checks = 0;
    int          passes = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance model.
    task automatic step(input bit r, input bit red, input logic [31:0] rpc,
                        input bit ack, input logic [31:0] ins, input bit rdy);
        bit push_ok, pop_ok;
        @(negedge clk);
        rst_i             = r;
        bus.redirect_i    = red;
        bus.redirect_pc_i = rpc;
        bus.mem_ack_i     = ack;
        bus.mem_instr_i   = ins;
        bus.instr_ready_i = rdy;
        #1;
        check_eq("mem_req", 64'(bus.mem_req_o), 64'(!r && model_init && q.size() < DEPTH));
        if (model_init) begin
            check_eq("mem_addr", 64'(bus.mem_addr_o), 64'(fpc));
            check_eq("valid", 64'(bus.instr_valid_o), 64'(q.size() != 0));
            check_eq("level", 64'(bus.level_o), 64'(q.size()));
            check_eq("pc_o", 64'(bus.pc_o), 64'(q.size() != 0 ? q[0].pc : 32'h0));
            check_eq("instr_o", 64'(bus.instr_o), 64'(q.size() != 0 ? q[0].instr : 32'h0));
        end
        @(posedge clk);
        if (r) begin
            q.delete();
            fpc = RST_PC;
            model_init = 1;
        end else if (model_init) begin
            if (red) begin
                q.delete();
                fpc = rpc;
            end else begin
                push_ok = ack && (q.size() < DEPTH);
                pop_ok  = rdy && (q.size() != 0);
                if (pop_ok) begin
                    $display("pop pc=%h instr=%h", q[0].pc, q[0].instr);
                    void'(q.pop_front());
                end
                if (push_ok) begin
                    q.push_back('{pc: fpc, instr: ins});
                    fpc = fpc + STEP;
                end
            end
        end
        #1;
    endtask

    initial begin
        rst_i             = 1'b1;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = '0;
        bus.mem_ack_i     = 1'b0;
        bus.mem_instr_i   = '0;
        bus.instr_ready_i = 1'b0;

        // Reset, then release with ack high and decode stalled.
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 32'hDEAD, 0);
        for (int n = 0; n < 6; n++) step(0, 0, 0, 1, 32'h1000 + n, 0);
        check_eq("rr_level", 64'(bus.level_o), 64'd4);
        check_eq("rr_req", 64'(bus.mem_req_o), 64'd0);
        check_eq("rr_addr", 64'(bus.mem_addr_o), 64'h110);
        check_eq("rr_pc", 64'(bus.pc_o), 64'h100);
        check_eq("rr_instr", 64'(bus.instr_o), 64'h1000);

        // Full with a single-cycle pop: 4 -> 3 -> 4.
        step(0, 0, 0, 1, 32'h2000, 1);
        check_eq("fp_level3", 64'(bus.level_o), 64'd3);
        check_eq("fp_req", 64'(bus.mem_req_o), 64'd1);
        step(0, 0, 0, 1, 32'h2001, 0);
        check_eq("fp_level4", 64'(bus.level_o), 64'd4);

        // Streaming from 0 with memory returning 0xA0+n.
        step(0, 1, 32'h0, 0, 0, 0);
        for (int n = 0; n < 12; n++) step(0, 0, 0, 1, 32'hA0 + n, 1);
        check_eq("st_level", 64'(bus.level_o), 64'd1);

        // Redirect with ack in the same cycle.
        step(0, 1, 32'h3000, 0, 0, 0);
        step(0, 0, 0, 1, 32'h3A, 0);
        step(0, 0, 0, 1, 32'h3B, 0);
        step(0, 1, 32'h2000, 1, 32'hBAD0BAD0, 1);
        check_eq("rd_level", 64'(bus.level_o), 64'd0);
        check_eq("rd_valid", 64'(bus.instr_valid_o), 64'd0);
        check_eq("rd_addr", 64'(bus.mem_addr_o), 64'h2000);
        step(0, 0, 0, 1, 32'h55, 0);
        check_eq("rd_pc", 64'(bus.pc_o), 64'h2000);
        check_eq("rd_instr", 64'(bus.instr_o), 64'h55);

        // Stalled memory at 0x40.
        step(0, 1, 32'h40, 0, 0, 0);
        for (int n = 0; n < 5; n++) step(0, 0, 0, 0, 32'hEE, 0);
        step(0, 0, 0, 1, 32'h4040, 0);
        check_eq("sm_pc", 64'(bus.pc_o), 64'h40);
        check_eq("sm_addr", 64'(bus.mem_addr_o), 64'h44);

        // PC wrap.
        step(0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        step(0, 0, 0, 1, 32'h71, 0);
        step(0, 0, 0, 1, 32'h72, 0);
        check_eq("pw_pc0", 64'(bus.pc_o), 64'hFFFF_FFFC);
        step(0, 0, 0, 0, 0, 1);
        check_eq("pw_pc1", 64'(bus.pc_o), 64'h0);

        // Pointer wrap: 10 push/pop pairs.
        for (int n = 0; n < 10; n++) step(0, 0, 0, 1, 32'h900 + n, 1);

        // Reset mid-run with 3 entries queued and a request pending.
        step(0, 1, 32'h500, 0, 0, 0);
        for (int n = 0; n < 3; n++) step(0, 0, 0, 1, 32'h600 + n, 0);
        step(1, 0, 0, 1, 32'hCAFE, 0);
        check_eq("mr_level", 64'(bus.level_o), 64'd0);
        check_eq("mr_addr", 64'(bus.mem_addr_o), 64'(RST_PC));
        check_eq("mr_instr", 64'(bus.instr_o), 64'd0);
        step(0, 0, 0, 0, 0, 0);

        // Random traffic.
        for (int n = 0; n < 2000; n++) begin
            step(($urandom % 256) == 0,
                 ($urandom % 32) == 0,
                 $urandom & 32'hFFFF_FFFC,
                 $urandom % 2,
                 $urandom,
                 ($urandom % 3) != 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/instruction_prefetch.md
Name: instruction_prefetch

Overview:
- Parametrised successor to the single-stage fetch stage.
- Decouples instruction memory from decode through a DEPTH-entry queue of {pc, instr} pairs, with valid/ready handshakes on both sides.
- Keeps a fetch PC that advances by PC_STEP per accepted memory transaction; a redirect (branch/exception) flushes the queue and restarts fetch at a new PC.
- Sits between the instruction memory port and decode.

Parameters:
ADDR_WIDTH, 32, width of fetch PC and memory address
INSTR_WIDTH, 32, width of instruction word
DEPTH, 4, queue entries; power of two, >= 2
RESET_PC, 0, fetch PC loaded on reset
PC_STEP, 4, PC increment per fetched instruction

Ports:
clk  input  1  clock; all state changes on posedge
rst_i  input  1  synchronous active-high reset
redirect_i  input  1  flush queue, restart fetch at redirect_pc_i
redirect_pc_i  input  ADDR_WIDTH  redirect target
mem_req_o  output  1  fetch request valid
mem_addr_o  output  ADDR_WIDTH  fetch address (current fetch PC)
mem_ack_i  input  1  memory accepts request; mem_instr_i valid this cycle
mem_instr_i  input  INSTR_WIDTH  fetched instruction
instr_valid_o  output  1  queue head valid
instr_o  output  INSTR_WIDTH  head instruction
pc_o  output  ADDR_WIDTH  head instruction's PC
instr_ready_i  input  1  decode consumes head when high with instr_valid_o
level_o  output  clog2(DEPTH+1)  current entry count

Behaviour:
- Reset (rst_i high at posedge), priority over everything:
  - fetch_pc = RESET_PC; queue emptied; level_o = 0; instr_valid_o = 0.
  - Storage contents are irrelevant; instr_o = 0 and pc_o = 0 in the cycle after reset.
  - Reset mid-handshake abandons the request; ack in that cycle is ignored.
- Outputs:
  - mem_req_o = !rst_i && (level < DEPTH); decoded from registered state and rst_i only, never from mem_ack_i or instr_ready_i.
  - mem_addr_o = fetch_pc, registered.
  - instr_valid_o = (level != 0).
  - instr_o and pc_o show the head entry directly from storage, with no extra register stage.
- Push:
  - Occurs when mem_req_o && mem_ack_i && !redirect_i.
  - Writes {fetch_pc, mem_instr_i} at the tail; fetch_pc += PC_STEP, modulo 2^ADDR_WIDTH (wraps silently).
- Pop:
  - Occurs when instr_valid_o && instr_ready_i && !redirect_i; the head advances.
- Push and pop in the same cycle: level unchanged; head and tail both advance.
- Full (level == DEPTH):
  - mem_req_o low, even if a pop occurs this cycle (no full-bypass).
  - Requests resume the cycle after level drops below DEPTH.
- Empty: instr_valid_o low; no bypass from memory to output, so minimum fetch-to-decode latency is 1 cycle after ack.
- Pointers:
  - Head and tail are clog2(DEPTH) bits and wrap modulo DEPTH.
  - level is tracked separately, which is what distinguishes full from empty.
- Redirect (redirect_i high, rst_i low):
  - Next cycle: queue empty, level_o = 0, fetch_pc = redirect_pc_i.
  - Any ack in the redirect cycle is discarded: no push and no PC increment.
  - Any pop in the redirect cycle is suppressed.
  - mem_req_o may be withdrawn or re-addressed mid-request on redirect; the memory side must tolerate this.
- Handshake stability: with mem_req_o high and mem_ack_i low, mem_addr_o holds, except on redirect or reset.
- Ordering: entries leave in exactly the order accepted. pc_o of successive pops increases by PC_STEP, unless a redirect intervenes.

Test Plan:
- Reset release: RESET_PC=0x100, mem_ack_i tied high, instr_ready_i low.
  - Expected: 4 pushes at pc 0x100/0x104/0x108/0x10C; level_o=4; mem_req_o drops; mem_addr_o holds 0x110.
  - Head: pc_o=0x100 with its word.
- Streaming: ack and ready both tied high.
  - Expected: steady state level_o=1 with one instruction per cycle; pc_o sequence 0x0, 0x4, 0x8...
  - Memory returning 0xA0+n yields instr_o matching in order.
- Full with simultaneous pop: queue full, then ready pulsed for 1 cycle.
  - Expected: mem_req_o stays low in the pop cycle, rises the next cycle, and level_o goes 4 -> 3 -> 4 after the following ack.
- Redirect with ack in the same cycle: queue holds 2 entries; redirect_i=1, redirect_pc_i=0x2000, mem_ack_i=1.
  - Expected next cycle: level_o=0, instr_valid_o=0, mem_addr_o=0x2000, and the acked word is never output.
  - First subsequent entry: pc_o=0x2000.
- Stalled memory: mem_ack_i low for 5 cycles at mem_addr_o=0x40.
  - Expected: mem_req_o high and address stable throughout.
  - On ack: entry pc 0x40, next address 0x44.
- Wrap and reset mid-run:
  - PC wrap: redirect to 0xFFFFFFFC, two acks -> pc_o 0xFFFFFFFC then 0x00000000.
  - Pointer wrap: run 10 push/pop pairs and check ordering.
  - Reset: assert rst_i with 3 entries queued and a request pending -> next cycle level_o=0, mem_addr_o=RESET_PC, mem_req_o low during the reset cycle.
